// File: rtl/sfx_pkg.sv
// sfx_pkg: shared types, effect IDs and per-effect tone/duration tables
// for the sound-effect sequencer.
package sfx_pkg;

  localparam int NUM_SFX = 4;
  localparam int HALF_W  = 17;
  localparam int FRAME_W = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } sfx_state_e;

  // Effect IDs; a higher ID wins arbitration.
  localparam logic [1:0] WALL   = 2'd0;
  localparam logic [1:0] PADDLE = 2'd1;
  localparam logic [1:0] BLOCK  = 2'd2;
  localparam logic [1:0] LOST   = 2'd3;

  // Tone half-period in clock cycles, indexed by effect ID.
  localparam logic [HALF_W-1:0] HALF_PERIOD [NUM_SFX] =
    '{17'd20000, 17'd13333, 17'd10000, 17'd80000};

  // Effect length in video frames, indexed by effect ID.
  localparam logic [FRAME_W-1:0] DURATION [NUM_SFX] =
    '{5'd3, 5'd4, 5'd3, 5'd20};

  // Fixed-priority pick: ID of the highest set bit (0 when empty).
  function automatic logic [1:0] top_id(input logic [NUM_SFX-1:0] set);
    logic [1:0] id;
    id = 2'd0;
    for (int i = 0; i < NUM_SFX; i++) begin
      if (set[i]) begin
        id = i[1:0];
      end else begin
        id = id;
      end
    end
    return id;
  endfunction

  // One-hot mask for an effect ID.
  function automatic logic [NUM_SFX-1:0] id_mask(input logic [1:0] id);
    return 4'b0001 << id;
  endfunction

endpackage

// File: rtl/sfx_tone_gen.sv
// sfx_tone_gen: square-wave generator. start_i restarts the wave high with
// a cleared phase counter, stop_i forces it low and idle. While running the
// output toggles every half_i cycles.
module sfx_tone_gen
  import sfx_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [HALF_W-1:0] half_i,
  output logic              audio_o
);

  logic [HALF_W-1:0] cnt_q, cnt_d;
  logic              audio_q, audio_d;
  logic              run_q, run_d;

  // Next-state: start/stop override, otherwise count and toggle at half-1.
  always_comb begin
    cnt_d   = cnt_q;
    audio_d = audio_q;
    run_d   = run_q;
    if (start_i) begin
      cnt_d   = '0;
      audio_d = 1'b1;
      run_d   = 1'b1;
    end else if (stop_i) begin
      cnt_d   = '0;
      audio_d = 1'b0;
      run_d   = 1'b0;
    end else if (run_q) begin
      // Written as cnt+1 >= half so a zero half-period cannot wrap.
      if ((cnt_q + 17'd1) >= half_i) begin
        cnt_d   = '0;
        audio_d = ~audio_q;
      end else begin
        cnt_d   = cnt_q + 17'd1;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Tone registers with synchronous reset to silence.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      audio_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      audio_q <= audio_d;
      run_q   <= run_d;
    end
  end

  assign audio_o = audio_q;

endmodule

// File: rtl/sfx_sequencer.sv
// sfx_sequencer: arbitrates four game-event requesters onto one audio pin,
// queues one request per source and sequences PLAY / GAP phases timed by the
// frame tick. Build option: define SFX_PREEMPT_EN to let a higher-priority
// request cut into a playing effect; undefined, it is only queued.
module sfx_sequencer
  import sfx_pkg::*;
#(
  parameter int TONE_SHIFT = 0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               FRAME_TICK,
  input  logic [NUM_SFX-1:0] REQ,
  output logic               AUDIO,
  output logic               BUSY,
  output logic [1:0]         ACTIVE_ID
);

  sfx_state_e         state_q, state_d;
  logic [NUM_SFX-1:0] pend_q, pend_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [1:0]         id_q, id_d;
  logic               busy_q;

  logic [NUM_SFX-1:0] cand_s;
  logic [1:0]         win_s;
  logic               same_req_s;
  logic [NUM_SFX-1:0] other_req_s;
  logic               preempt_s;
  logic [1:0]         preempt_id_s;
  logic               tone_start_s;
  logic               tone_stop_s;
  logic [HALF_W-1:0]  half_s;

  assign cand_s      = pend_q | REQ;
  assign win_s       = top_id(cand_s);
  assign same_req_s  = |(REQ & id_mask(id_q));
  assign other_req_s = REQ & ~id_mask(id_q);
  assign half_s      = HALF_PERIOD[id_q] >> TONE_SHIFT;

`ifdef SFX_PREEMPT_EN
  logic [NUM_SFX-1:0] hi_req_s;
  // Requests strictly above the active effect's priority.
  assign hi_req_s     = REQ & ~((id_mask(id_q) << 1) - 4'd1);
  assign preempt_s    = |hi_req_s;
  assign preempt_id_s = top_id(hi_req_s);
`else
  assign preempt_s    = 1'b0;
  assign preempt_id_s = 2'd0;
`endif

  // Sequencer next-state: arbitration, queueing, frame timing, tone control.
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    frame_d      = frame_q;
    id_d         = id_q;
    tone_start_s = 1'b0;
    tone_stop_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|cand_s) begin
          state_d      = S_PLAY;
          id_d         = win_s;
          pend_d       = cand_s & ~id_mask(win_s);
          frame_d      = '0;
          tone_start_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PLAY: begin
        // Any other source requesting is queued; same-ID requests are not.
        pend_d = pend_q | other_req_s;
        if (preempt_s) begin
          // The preempted effect is dropped; the new one starts afresh.
          id_d         = preempt_id_s;
          pend_d       = (pend_q | other_req_s) & ~id_mask(preempt_id_s);
          frame_d      = '0;
          tone_start_s = 1'b1;
        end else if (same_req_s) begin
          // Retrigger restarts the duration only; a coincident tick counts.
          frame_d = FRAME_TICK ? 5'd1 : 5'd0;
        end else if (FRAME_TICK) begin
          if ((frame_q + 5'd1) >= DURATION[id_q]) begin
            state_d     = S_GAP;
            frame_d     = '0;
            tone_stop_s = 1'b1;
          end else begin
            frame_d = frame_q + 5'd1;
          end
        end else begin
          frame_d = frame_q;
        end
      end
      S_GAP: begin
        pend_d = pend_q | REQ;
        if (FRAME_TICK) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_GAP;
        end
      end
      default: begin
        state_d     = S_IDLE;
        tone_stop_s = 1'b1;
      end
    endcase
  end

  // Sequencer state registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      frame_q <= '0;
      id_q    <= 2'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      frame_q <= frame_d;
      id_q    <= id_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  sfx_tone_gen u_tone (
    .clk_i   (CLK),
    .rst_i   (RST),
    .start_i (tone_start_s),
    .stop_i  (tone_stop_s),
    .half_i  (half_s),
    .audio_o (AUDIO)
  );

  assign BUSY      = busy_q;
  assign ACTIVE_ID = id_q;

endmodule

// File: tb/tb_sfx_sequencer.sv
// tb_sfx_sequencer: directed scenarios with a scoreboard of expected effect
// start/end events (ID and cycle), plus point checks of AUDIO timing.
module tb_sfx_sequencer;
  import sfx_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       FRAME_TICK = 1'b0;
  logic [3:0] REQ = 4'd0;
  logic       AUDIO, BUSY;
  logic [1:0] ACTIVE_ID;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int t;

  typedef struct {
    bit         is_start;
    logic [1:0] id;
    int         at;
  } ev_t;
  ev_t exp_q[$];

  bit         mon_en = 1'b0;
  logic       busy_prev = 1'b0;
  logic [1:0] id_prev = 2'd0;

  sfx_sequencer #(.TONE_SHIFT(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .FRAME_TICK (FRAME_TICK),
    .REQ        (REQ),
    .AUDIO      (AUDIO),
    .BUSY       (BUSY),
    .ACTIVE_ID  (ACTIVE_ID)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_ev(input bit is_start, input logic [1:0] id, input int at);
    ev_t e;
    e.is_start = is_start;
    e.id = id;
    e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic got_ev(input bit is_start, input logic [1:0] id);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_event: got start=%0d id=%0d at cycle %0d, expected none", is_start, id, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(is_start), 32'(e.is_start));
      if (e.is_start) check("event_id", 32'(id), 32'(e.id));
      check("event_cycle", cyc, e.at);
    end
  endtask

  // Monitor: detect effect start (BUSY rise or ID change) and end (BUSY fall).
  always @(negedge CLK) begin
    if (mon_en) begin
      if (BUSY === 1'b1 && (busy_prev !== 1'b1 || ACTIVE_ID !== id_prev))
        got_ev(1'b1, ACTIVE_ID);
      else if (BUSY !== 1'b1 && busy_prev === 1'b1)
        got_ev(1'b0, 2'd0);
    end
    busy_prev = BUSY;
    id_prev = ACTIVE_ID;
  end

  // One cycle of stimulus; called and returns #1 after a rising edge.
  task automatic step(input logic rst, input logic [3:0] req, input logic tick);
    RST = rst;
    REQ = req;
    FRAME_TICK = tick;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    REQ = 4'd0;
    FRAME_TICK = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 4'd0, 1'b0);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      idle(7);
      step(1'b0, 4'd0, 1'b1);
    end
  endtask

  task automatic quiet(input string name, input int n);
    bit seen;
    seen = 1'b0;
    repeat (n) begin
      if (AUDIO !== 1'b0) seen = 1'b1;
      idle(1);
    end
    check(name, 32'(seen), 32'd0);
  endtask

  task automatic saw_high(input string name, input int n);
    bit seen;
    seen = 1'b0;
    repeat (n) begin
      if (AUDIO === 1'b1) seen = 1'b1;
      idle(1);
    end
    check(name, 32'(seen), 32'd1);
  endtask

  initial begin
    @(posedge CLK);
    #1;
    step(1'b1, 4'd0, 1'b0);
    check("reset_audio", 32'(AUDIO), 32'd0);
    check("reset_busy", 32'(BUSY), 32'd0);
    check("reset_id", 32'(ACTIVE_ID), 32'd0);
    mon_en = 1'b1;
    idle(2);

    // PADDLE alone: half = 13333>>8 = 52, duration 4 frames.
    t = cyc; exp_ev(1'b1, PADDLE, t + 1);
    step(1'b0, 4'b0010, 1'b0);
    check("grant_busy", 32'(BUSY), 32'd1);
    check("grant_id", 32'(ACTIVE_ID), 32'd1);
    check("grant_audio", 32'(AUDIO), 32'd1);
    idle(51);
    check("pre_toggle_audio", 32'(AUDIO), 32'd1);
    idle(1);
    check("first_toggle_audio", 32'(AUDIO), 32'd0);
    frames(4);
    check("gap_busy", 32'(BUSY), 32'd1);
    check("gap_audio", 32'(AUDIO), 32'd0);
    quiet("gap_quiet", 60);
    t = cyc; exp_ev(1'b0, 2'd0, t + 1);
    step(1'b0, 4'd0, 1'b1);
    check("idle_holds_id", 32'(ACTIVE_ID), 32'd1);
    idle(3);

    // BLOCK + WALL together: BLOCK plays, WALL follows at g+2.
    t = cyc; exp_ev(1'b1, BLOCK, t + 1);
    step(1'b0, 4'b0101, 1'b0);
    frames(3);
    idle(7);
    t = cyc; exp_ev(1'b0, 2'd0, t + 1); exp_ev(1'b1, WALL, t + 2);
    step(1'b0, 4'd0, 1'b1);
    idle(1);

    // LOST requested during WALL.
    frames(1);
    idle(3);
`ifdef SFX_PREEMPT_EN
    t = cyc; exp_ev(1'b1, LOST, t + 1);
    step(1'b0, 4'b1000, 1'b0);
    check("preempt_audio", 32'(AUDIO), 32'd1);
    check("preempt_busy", 32'(BUSY), 32'd1);
`else
    step(1'b0, 4'b1000, 1'b0);
    frames(2);
    idle(7);
    t = cyc; exp_ev(1'b0, 2'd0, t + 1); exp_ev(1'b1, LOST, t + 2);
    step(1'b0, 4'd0, 1'b1);
    idle(1);
`endif

    // PADDLE pulsed twice during LOST: plays once afterwards.
    idle(5);
    step(1'b0, 4'b0010, 1'b0);
    idle(20);
    step(1'b0, 4'b0010, 1'b0);
    frames(20);
    idle(7);
    t = cyc; exp_ev(1'b0, 2'd0, t + 1); exp_ev(1'b1, PADDLE, t + 2);
    step(1'b0, 4'd0, 1'b1);
    idle(1);
    frames(4);
    idle(7);
    t = cyc; exp_ev(1'b0, 2'd0, t + 1);
    step(1'b0, 4'd0, 1'b1);
    idle(60);

    // Retrigger BLOCK after 2 ticks: 3 further ticks to reach GAP.
    t = cyc; exp_ev(1'b1, BLOCK, t + 1);
    step(1'b0, 4'b0100, 1'b0);
    frames(2);
    idle(3);
    step(1'b0, 4'b0100, 1'b0);
    frames(2);
    check("retrig_busy", 32'(BUSY), 32'd1);
    saw_high("retrig_still_playing", 80);
    frames(1);
    quiet("retrig_gap_quiet", 50);
    idle(2);
    t = cyc; exp_ev(1'b0, 2'd0, t + 1);
    step(1'b0, 4'd0, 1'b1);
    idle(3);

    // Reset mid-LOST with WALL queued: everything cleared, WALL never plays.
    t = cyc; exp_ev(1'b1, LOST, t + 1);
    step(1'b0, 4'b1000, 1'b0);
    frames(2);
    step(1'b0, 4'b0001, 1'b0);
    idle(10);
    t = cyc; exp_ev(1'b0, 2'd0, t + 1);
    step(1'b1, 4'd0, 1'b0);
    check("midreset_audio", 32'(AUDIO), 32'd0);
    check("midreset_busy", 32'(BUSY), 32'd0);
    check("midreset_id", 32'(ACTIVE_ID), 32'd0);
    idle(40);
    check("midreset_no_pend", 32'(BUSY), 32'd0);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
